// File: rtl/huffman_encoder.sv
// ---------------------------------------------------------------------------
// huffman_encoder
//
// Serial Huffman encoder with a writable 256-entry code table. Each symbol
// accepted on the char_* handshake is looked up in the table and its code is
// shifted out MSB-first, one bit per accepted bit_* handshake.
//
// Ports:
//   clk         system clock, all state changes on its rising edge
//   rst         synchronous active-high reset (clears FSM and whole table)
//   tbl_we      code-table write strobe
//   tbl_char    table index (symbol) being written
//   tbl_code    code bits for tbl_char (low tbl_len bits meaningful)
//   tbl_len     code length: 1..12 valid, 0 unmapped, 13..15 illegal
//   char_valid  symbol offered on char_in
//   char_in     symbol to encode
//   char_ready  encoder can accept a symbol this cycle (IDLE)
//   bit_out     current serial code bit
//   bit_valid   bit_out is valid (SHIFT)
//   bit_ready   downstream accepts bit_out this cycle
//   bit_last    bit_out is the final bit of the current code
//   err         one-cycle pulse: accepted symbol had unmapped/illegal length
// ---------------------------------------------------------------------------
module huffman_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        tbl_we,
    input  logic [7:0]  tbl_char,
    input  logic [11:0] tbl_code,
    input  logic [3:0]  tbl_len,
    input  logic        char_valid,
    input  logic [7:0]  char_in,
    output logic        char_ready,
    output logic        bit_out,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        bit_last,
    output logic        err
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t      state_reg;
    logic [11:0] shift_reg;
    logic [3:0]  cnt_reg;
    logic        err_reg;

    // Entry layout: {code[11:0], len[3:0]}.
    logic [15:0] tbl_mem [256];

    logic [15:0] rd_entry;
    logic [11:0] rd_code;
    logic [3:0]  rd_len;
    logic        rd_len_ok;

    // Table storage. Every entry is cleared on reset, so this is a register
    // file rather than a RAM. Reset wins over a concurrent write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                tbl_mem[i] <= '0;
            end
        end else if (tbl_we) begin
            tbl_mem[tbl_char] <= {tbl_code, tbl_len};
        end
    end

    // The lookup is sampled into the shift register at the acceptance edge,
    // so a write landing on the same edge is not seen (read-before-write).
    // Writes during SHIFT cannot disturb the captured code either.
    always_comb begin
        rd_entry  = tbl_mem[char_in];
        rd_code   = rd_entry[15:4];
        rd_len    = rd_entry[3:0];
        rd_len_ok = (rd_len != 4'd0) && (rd_len <= 4'd12);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (char_valid) begin
                        if (rd_len_ok) begin
                            shift_reg <= rd_code;
                            cnt_reg   <= rd_len - 4'd1;
                            state_reg <= SHIFT;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // The counter doubles as the bit index: it walks from
                    // len-1 down to 0, giving MSB-first order without shifting.
                    if (bit_ready) begin
                        if (cnt_reg == 4'd0) begin
                            state_reg <= IDLE;
                        end else begin
                            cnt_reg <= cnt_reg - 4'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // All outputs decode purely from registered state.
    always_comb begin
        char_ready = (state_reg == IDLE);
        bit_valid  = (state_reg == SHIFT);
        bit_out    = (state_reg == SHIFT) && shift_reg[cnt_reg];
        bit_last   = (state_reg == SHIFT) && (cnt_reg == 4'd0);
        err        = err_reg;
    end

endmodule

// File: tb/tb_huffman_encoder.sv
// ---------------------------------------------------------------------------
// tb_huffman_encoder
//
// Scoreboard bench for huffman_encoder. The stimulus side keeps a model table
// (code/len per symbol); on each symbol acceptance it expands the model entry
// into the expected sequence of (bit, last) items, or a single error item,
// and queues them. A forked monitor pops and compares whenever the DUT
// transfers a bit or pulses err. Directed sections check timing points.
// Inputs change 1 ns after the rising edge; the monitor samples on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_huffman_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        tbl_we;
    logic [7:0]  tbl_char;
    logic [11:0] tbl_code;
    logic [3:0]  tbl_len;
    logic        char_valid;
    logic [7:0]  char_in;
    logic        char_ready;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        bit_last;
    logic        err;

    int   br_mode;      // 0: bit_ready = br_val, 1: random
    logic br_val;
    logic rnd_bit;
    assign bit_ready = (br_mode == 1) ? rnd_bit : br_val;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    huffman_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .tbl_we     (tbl_we),
        .tbl_char   (tbl_char),
        .tbl_code   (tbl_code),
        .tbl_len    (tbl_len),
        .char_valid (char_valid),
        .char_in    (char_in),
        .char_ready (char_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_last   (bit_last),
        .err        (err)
    );

    typedef struct {
        bit is_err;
        bit b;
        bit last;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] m_code [256];
    logic [3:0]  m_len  [256];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not allowed here (t=%0t)", name, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            m_code[i] = '0;
            m_len[i]  = '0;
        end
    endtask

    // Expand a symbol into expected output items from the model table.
    task automatic push_expected(input logic [7:0] c);
        int l;
        exp_t e;
        l = int'(m_len[c]);
        if (l == 0 || l > 12) begin
            e = '{1'b1, 1'b0, 1'b0};
            sb.push_back(e);
        end else begin
            for (int i = l - 1; i >= 0; i--) begin
                e = '{1'b0, m_code[c][i], (i == 0)};
                sb.push_back(e);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_tbl(input logic [7:0] ch, input logic [11:0] code, input logic [3:0] len);
        tbl_we   = 1'b1;
        tbl_char = ch;
        tbl_code = code;
        tbl_len  = len;
        m_code[ch] = code;
        m_len[ch]  = len;
        step(1);
        tbl_we = 1'b0;
    endtask

    // Offer symbol c until accepted; optionally write the table in the
    // acceptance cycle. acc = cycle number of the acceptance edge.
    task automatic send(input logic [7:0] c, input bit wr, input logic [7:0] wch,
                        input logic [11:0] wcode, input logic [3:0] wlen, output int acc);
        int n;
        n   = 0;
        acc = -1;
        char_valid = 1'b1;
        char_in    = c;
        while (!char_ready && n < 1000) begin
            step(1);
            n++;
        end
        if (!char_ready) begin
            fail("send_timeout");
            char_valid = 1'b0;
        end else begin
            push_expected(c);   // old entry, before any same-cycle write
            if (wr) begin
                tbl_we   = 1'b1;
                tbl_char = wch;
                tbl_code = wcode;
                tbl_len  = wlen;
                m_code[wch] = wcode;
                m_len[wch]  = wlen;
            end
            acc = cyc;
            step(1);
            char_valid = 1'b0;
            tbl_we     = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        sb.delete();
        model_clear();
        rst = 1'b0;
    endtask

    initial begin
        int a0, a1, dummy, r, n;
        exp_t e;

        rst = 1'b1; tbl_we = 1'b0; tbl_char = '0; tbl_code = '0; tbl_len = '0;
        char_valid = 1'b0; char_in = '0; br_mode = 0; br_val = 1'b1; rnd_bit = 1'b1;
        model_clear();

        fork
            forever begin
                @(posedge clk);
                #1;
                rnd_bit = 1'($urandom_range(0, 1));
            end
            forever begin
                @(negedge clk);
                if (!rst) begin
                    check("ready_xor_valid", char_ready, !bit_valid);
                    if (!bit_valid) begin
                        check("idle_bit_out", bit_out, 0);
                        check("idle_bit_last", bit_last, 0);
                    end
                    if (err) begin
                        check("err_with_bit", bit_valid, 0);
                        if (sb.size() == 0) fail("err_unexpected");
                        else begin
                            e = sb.pop_front();
                            check("err_order", e.is_err, 1);
                        end
                    end
                    if (bit_valid && bit_ready) begin
                        if (sb.size() == 0) fail("bit_unexpected");
                        else begin
                            e = sb.pop_front();
                            check("bit_not_err", e.is_err, 0);
                            check("bit_out", bit_out, e.b);
                            check("bit_last", bit_last, e.last);
                        end
                    end
                end
            end
        join_none

        step(1);
        do_reset();

        // Reset state
        check("rst_char_ready", char_ready, 1);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_bit_out", bit_out, 0);
        check("rst_bit_last", bit_last, 0);
        check("rst_err", err, 0);

        // Unmapped symbol after reset
        send(8'h7F, 0, 0, 0, 0, a0);
        check("unmapped_err", err, 1);
        check("unmapped_valid", bit_valid, 0);
        check("unmapped_ready", char_ready, 1);
        step(1);
        check("unmapped_err_1cyc", err, 0);
        $display("txn unmapped 0x7F done");

        // Basic encode: 'A' -> 1,0,1
        wr_tbl(8'h41, 12'h005, 4'd3);
        send(8'h41, 0, 0, 0, 0, a0);
        check("basic_first_valid", bit_valid, 1);
        check("basic_first_bit", bit_out, 1);
        step(3);
        check("basic_ready_again", char_ready, 1);
        check("basic_valid_off", bit_valid, 0);
        $display("txn basic 0x41 done");

        // Backpressure: 1,0,1,0 with first bit held three cycles
        wr_tbl(8'h42, 12'h00A, 4'd4);
        send(8'h42, 0, 0, 0, 0, a0);
        br_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", bit_valid, 1);
            check("bp_hold_bit", bit_out, 1);
            check("bp_hold_last", bit_last, 0);
            step(1);
        end
        br_val = 1'b1;
        step(4);
        check("bp_done", bit_valid, 0);
        $display("txn backpressure 0x42 done");

        // Collision: old entry {3,2} used while {0,1} is written
        wr_tbl(8'h10, 12'h003, 4'd2);
        send(8'h10, 1, 8'h10, 12'h000, 4'd1, a0);
        step(2);
        send(8'h10, 0, 0, 0, 0, a0);
        step(1);
        check("coll_idle", bit_valid, 0);
        $display("txn collision 0x10 done");

        // Max length, back-to-back
        wr_tbl(8'h20, 12'hFFF, 4'd12);
        send(8'h20, 0, 0, 0, 0, a0);
        send(8'h20, 0, 0, 0, 0, a1);
        check("max_period", a1 - a0, 13);
        step(12);
        check("max_idle", bit_valid, 0);
        $display("txn maxlen 0x20 x2 done");

        // Reset during the 2nd bit of a len=5 code
        wr_tbl(8'h30, 12'h015, 4'd5);
        send(8'h30, 0, 0, 0, 0, a0);
        step(1);
        rst = 1'b1;
        step(1);
        check("rstmid_valid", bit_valid, 0);
        sb.delete();
        model_clear();
        rst = 1'b0;
        step(1);
        check("rstmid_still_idle", bit_valid, 0);
        send(8'h30, 0, 0, 0, 0, a0);
        check("rstmid_err", err, 1);
        step(1);
        $display("txn reset-mid-shift 0x30 done");

        // Randomized traffic with random backpressure
        br_mode = 1;
        for (int k = 0; k < 250; k++) begin
            r = int'($urandom_range(0, 4));
            if (r == 0) begin
                wr_tbl(8'($urandom_range(0, 15)), 12'($urandom),
                       4'($urandom_range(0, 15)));
            end else if (r == 1) begin
                send(8'($urandom_range(0, 15)), 1, 8'($urandom_range(0, 15)),
                     12'($urandom), 4'($urandom_range(0, 14)), dummy);
            end else begin
                send(8'($urandom_range(0, 15)), 0, 0, 0, 0, dummy);
            end
            step(int'($urandom_range(0, 1)));
        end
        $display("txn random phase done");

        // Drain
        br_mode = 0;
        br_val  = 1'b1;
        n = 0;
        while ((sb.size() != 0 || bit_valid) && n < 100) begin
            step(1);
            n++;
        end
        check("drain_queue", sb.size(), 0);
        check("drain_idle", bit_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
